rvfi_shadow_pipe: RTL

Synthesizable, parametrised shadow pipeline that carries per-instruction RVFI monitor data alongside the CPU datapath from capture (ID/EX boundary) to commit (WB). Generalises the hand-written ex/mem/wb monitor registers to DEPTH stages with a configurable memory-capture stage, selective flush, a 64-bit order counter and sticky halt detection. Instantiated by the testbench top and optionally inside the core for on-chip trace.

---
 rtl/rvfi_shadow_pkg.sv | 26 ++
 rtl/rvfi_shadow_stage.sv | 42 ++++
 rtl/rvfi_shadow_pipe.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rvfi_shadow_pkg.sv
// rvfi_shadow_pkg: shared shadow-entry layout, reset value and saturating increment helper.
// Field widths are fixed by SHADOW_XLEN; the top-level XLEN parameter must match it.
package rvfi_shadow_pkg;
    localparam int SHADOW_XLEN   = 32;
    localparam int SHADOW_MASK_W = SHADOW_XLEN / 8;

    typedef struct packed {
        logic                     valid;
        logic [31:0]              inst;
        logic [SHADOW_XLEN-1:0]   pc_rdata;
        logic [SHADOW_XLEN-1:0]   pc_wdata;
        logic [SHADOW_XLEN-1:0]   rs1_rdata;
        logic [SHADOW_XLEN-1:0]   rs2_rdata;
        logic [SHADOW_XLEN-1:0]   mem_addr;
        logic [SHADOW_XLEN-1:0]   mem_wdata;
        logic [SHADOW_XLEN-1:0]   mem_rdata;
        logic [SHADOW_MASK_W-1:0] mem_rmask;
        logic [SHADOW_MASK_W-1:0] mem_wmask;
    } shadow_entry_t;

    localparam shadow_entry_t SHADOW_ENTRY_RESET = '0;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction
endpackage

// File: rtl/rvfi_shadow_stage.sv
// rvfi_shadow_stage: one shadow pipeline register with hold, valid-flush and optional
// memory-field capture on the incoming entry.
module rvfi_shadow_stage
    import rvfi_shadow_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_hold,
    input  logic                     i_flush,
    input  logic                     i_mem_cap,
    input  logic                     i_mem_read,
    input  logic                     i_mem_write,
    input  logic [SHADOW_MASK_W-1:0] i_mem_mbe,
    input  logic [SHADOW_XLEN-1:0]   i_mem_addr,
    input  logic [SHADOW_XLEN-1:0]   i_mem_wdata,
    input  logic [SHADOW_XLEN-1:0]   i_mem_rdata,
    input  shadow_entry_t            i_d,
    output shadow_entry_t            o_q
);
    shadow_entry_t r_q;
    shadow_entry_t w_adv;
    shadow_entry_t w_next;

    always_comb begin
        w_adv           = i_d;
        w_adv.mem_addr  = i_mem_cap ? i_mem_addr  : i_d.mem_addr;
        w_adv.mem_wdata = i_mem_cap ? i_mem_wdata : i_d.mem_wdata;
        w_adv.mem_rdata = i_mem_cap ? i_mem_rdata : i_d.mem_rdata;
        w_adv.mem_rmask = i_mem_cap ? (i_mem_read  ? i_mem_mbe : '0) : i_d.mem_rmask;
        w_adv.mem_wmask = i_mem_cap ? (i_mem_write ? i_mem_mbe : '0) : i_d.mem_wmask;
        w_next          = i_hold ? r_q : w_adv;
        // flush wins over both hold and advance, but only kills the valid bit
        w_next.valid    = w_next.valid & ~i_flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_q <= SHADOW_ENTRY_RESET;
        else      r_q <= w_next;
    end

    assign o_q = r_q;
endmodule

// File: rtl/rvfi_shadow_pipe.sv
// rvfi_shadow_pipe: DEPTH-stage RVFI shadow pipeline with retire order, sticky halt and,
// when RVFI_SHADOW_PERF_EN is defined, saturating load/store/stall counters.
module rvfi_shadow_pipe
    import rvfi_shadow_pkg::*;
#(
    parameter int DEPTH        = 3,
    parameter int XLEN         = SHADOW_XLEN,
    parameter int MEM_STAGE    = 1,
    parameter int FLUSH_STAGES = 2,
    parameter int ORDER_W      = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                cap_valid_i,
    input  logic [31:0]         cap_inst_i,
    input  logic [XLEN-1:0]     cap_pc_rdata_i,
    input  logic [XLEN-1:0]     cap_pc_wdata_i,
    input  logic [XLEN-1:0]     cap_rs1_rdata_i,
    input  logic [XLEN-1:0]     cap_rs2_rdata_i,
    input  logic                mem_read_i,
    input  logic                mem_write_i,
    input  logic [XLEN/8-1:0]   mem_mbe_i,
    input  logic [XLEN-1:0]     mem_addr_i,
    input  logic [XLEN-1:0]     mem_wdata_i,
    input  logic [XLEN-1:0]     mem_rdata_i,
    output logic                commit_o,
    output logic [ORDER_W-1:0]  order_o,
    output logic                halt_o,
    output logic [31:0]         inst_o,
    output logic [XLEN-1:0]     pc_rdata_o,
    output logic [XLEN-1:0]     pc_wdata_o,
    output logic [XLEN-1:0]     rs1_rdata_o,
    output logic [XLEN-1:0]     rs2_rdata_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    output logic [XLEN-1:0]     mem_rdata_o,
    output logic [XLEN/8-1:0]   mem_rmask_o,
    output logic [XLEN/8-1:0]   mem_wmask_o,
    output logic [31:0]         perf_loads_o,
    output logic [31:0]         perf_stores_o,
    output logic [31:0]         perf_stall_cyc_o
);
    shadow_entry_t w_cap;
    shadow_entry_t w_d     [DEPTH];
    shadow_entry_t w_stage [DEPTH];
    shadow_entry_t w_head;
    logic          w_commit;
    logic [ORDER_W-1:0] r_order;
    logic          r_halt;

    always_comb begin
        w_cap           = SHADOW_ENTRY_RESET;
        w_cap.valid     = cap_valid_i;
        w_cap.inst      = cap_inst_i;
        w_cap.pc_rdata  = cap_pc_rdata_i;
        w_cap.pc_wdata  = cap_pc_wdata_i;
        w_cap.rs1_rdata = cap_rs1_rdata_i;
        w_cap.rs2_rdata = cap_rs2_rdata_i;
    end

    // the stage after MEM_STAGE samples the dcache bus as the entry moves into it
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_d[k] = w_cap;
        end else begin : g_tail
            assign w_d[k] = w_stage[k-1];
        end
        rvfi_shadow_stage u_stage (
            .clk         (clk),
            .rst         (rst),
            .i_hold      (stall_i),
            .i_flush     (flush_i && (k < FLUSH_STAGES)),
            .i_mem_cap   (k == MEM_STAGE + 1),
            .i_mem_read  (mem_read_i),
            .i_mem_write (mem_write_i),
            .i_mem_mbe   (mem_mbe_i),
            .i_mem_addr  (mem_addr_i),
            .i_mem_wdata (mem_wdata_i),
            .i_mem_rdata (mem_rdata_i),
            .i_d         (w_d[k]),
            .o_q         (w_stage[k])
        );
    end

    assign w_head   = w_stage[DEPTH-1];
    assign w_commit = w_head.valid & ~stall_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_order <= '0;
            r_halt  <= 1'b0;
        end else begin
            r_order <= r_order + ORDER_W'(w_commit);
            r_halt  <= r_halt | (w_commit & (w_head.pc_wdata == w_head.pc_rdata));
        end
    end

    assign commit_o    = w_commit;
    assign order_o     = r_order;
    assign halt_o      = r_halt;
    assign inst_o      = w_head.inst;
    assign pc_rdata_o  = w_head.pc_rdata;
    assign pc_wdata_o  = w_head.pc_wdata;
    assign rs1_rdata_o = w_head.rs1_rdata;
    assign rs2_rdata_o = w_head.rs2_rdata;
    assign mem_addr_o  = w_head.mem_addr;
    assign mem_wdata_o = w_head.mem_wdata;
    assign mem_rdata_o = w_head.mem_rdata;
    assign mem_rmask_o = w_head.mem_rmask;
    assign mem_wmask_o = w_head.mem_wmask;

`ifdef RVFI_SHADOW_PERF_EN
    logic [31:0] r_loads;
    logic [31:0] r_stores;
    logic [31:0] r_stall_cyc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_loads     <= '0;
            r_stores    <= '0;
            r_stall_cyc <= '0;
        end else begin
            r_loads     <= sat_inc(r_loads,  w_commit && (w_head.mem_rmask != '0));
            r_stores    <= sat_inc(r_stores, w_commit && (w_head.mem_wmask != '0));
            r_stall_cyc <= sat_inc(r_stall_cyc, stall_i);
        end
    end

    assign perf_loads_o     = r_loads;
    assign perf_stores_o    = r_stores;
    assign perf_stall_cyc_o = r_stall_cyc;
`else
    assign perf_loads_o     = 32'd0;
    assign perf_stores_o    = 32'd0;
    assign perf_stall_cyc_o = 32'd0;
`endif
endmodule
